// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ==========================================================================
// dmem_pkg : shared encodings for the MEM-stage data-memory responder
// Revision : 1.0
// ==========================================================================
package dmem_pkg;

   localparam logic [1:0]  SZ_B = 2'b00;
   localparam logic [1:0]  SZ_H = 2'b01;
   localparam logic [1:0]  SZ_W = 2'b10;

   localparam logic [31:0] DEFAULT_MMIO_ADDR = 32'h0000_1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ==========================================================================
// dmem_responder_if : request/response bus between MEM stage and responder
// Revision : 1.0
// ==========================================================================
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_lane_align.sv
`default_nettype none
// ==========================================================================
// dmem_lane_align : store byte-enable/lane replication, load extract/extend
// Revision : 1.0
// ==========================================================================
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_lanes,
   output logic [31:0] rdata_ext
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      byte_en     = 4'b0000;
      wdata_lanes = wdata;
      rdata_ext   = rword;
      rhalf       = addr_lo[1] ? rword[31:16] : rword[15:0];
      case (addr_lo)
         2'd0:    rbyte = rword[7:0];
         2'd1:    rbyte = rword[15:8];
         2'd2:    rbyte = rword[23:16];
         default: rbyte = rword[31:24];
      endcase
      // Store data is replicated across lanes; byte_en picks the live ones.
      case (size)
         SZ_B: begin
            byte_en     = 4'b0001 << addr_lo;
            wdata_lanes = {4{wdata[7:0]}};
            rdata_ext   = {{24{~is_unsigned & rbyte[7]}}, rbyte};
         end
         SZ_H: begin
            byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata[15:0]}};
            rdata_ext   = {{16{~is_unsigned & rhalf[15]}}, rhalf};
         end
         SZ_W: begin
            byte_en = 4'b1111;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ==========================================================================
// dmem_responder : single-outstanding data-memory responder with MMIO target
// Revision : 1.0
// ==========================================================================
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] MMIO_ADDR   = DEFAULT_MMIO_ADDR
)(
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   bus,
   output logic [3:0]        target
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state, next_state;
   logic [3:0]  wait_cnt;
   logic [31:0] cap_addr;
   logic [1:0]  cap_size;
   logic        cap_unsigned;
   logic [31:0] mem [DEPTH_WORDS];

   logic        in_idle, accept, req_mmio, req_err, store_ram, enter_resp;
   logic [31:0] eff_addr, rd_word, wdata_lanes, rdata_ext;
   logic [1:0]  eff_size;
   logic        eff_unsigned, eff_mmio;
   logic [3:0]  byte_en;
   logic [AW-1:0] ram_idx;

   assign in_idle       = (state == ST_IDLE);
   assign bus.req_ready = in_idle;
   assign bus.rsp_valid = (state == ST_RESP);
   assign accept        = bus.req_valid & in_idle;

   assign req_mmio = (bus.req_addr[31:2] == MMIO_ADDR[31:2]);
   assign req_err  = (bus.req_size == 2'b11)
                   | ((bus.req_size == SZ_H) & bus.req_addr[0])
                   | ((bus.req_size == SZ_W) & (bus.req_addr[1:0] != 2'b00))
                   | (~req_mmio & (bus.req_addr[31:2] >= 30'(DEPTH_WORDS)));

   // In IDLE the live request drives the datapath; afterwards the captured copy does.
   assign eff_addr     = in_idle ? bus.req_addr     : cap_addr;
   assign eff_size     = in_idle ? bus.req_size     : cap_size;
   assign eff_unsigned = in_idle ? bus.req_unsigned : cap_unsigned;
   assign eff_mmio     = (eff_addr[31:2] == MMIO_ADDR[31:2]);
   assign ram_idx      = eff_addr[AW+1:2];
   assign rd_word      = eff_mmio ? {28'b0, target} : mem[ram_idx];
   assign store_ram    = ~rst & accept & bus.req_write & ~req_err & ~req_mmio;

   dmem_lane_align u_lane_align (
      .addr_lo     (eff_addr[1:0]),
      .size        (eff_size),
      .is_unsigned (eff_unsigned),
      .wdata       (bus.req_wdata),
      .rword       (rd_word),
      .byte_en     (byte_en),
      .wdata_lanes (wdata_lanes),
      .rdata_ext   (rdata_ext)
   );

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (accept) begin
            if (req_err || bus.req_write || (WAIT_CYCLES == 0)) next_state = ST_RESP;
            else                                                 next_state = ST_WAIT;
         end
         ST_WAIT: if (wait_cnt == 4'd0) next_state = ST_RESP;
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt      <= 4'd0;
         cap_addr      <= 32'd0;
         cap_size      <= 2'd0;
         cap_unsigned  <= 1'b0;
         bus.rsp_rdata <= 32'd0;
         bus.rsp_err   <= 1'b0;
         target        <= 4'd0;
      end else begin
         if (accept) begin
            cap_addr     <= bus.req_addr;
            cap_size     <= bus.req_size;
            cap_unsigned <= bus.req_unsigned;
            wait_cnt     <= WAIT_LOAD;
            if (bus.req_write && !req_err && req_mmio) target <= bus.req_wdata[3:0];
         end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         // Only loads pass through WAIT, and they were already error-free.
         if (enter_resp) begin
            if (in_idle) begin
               bus.rsp_err   <= req_err;
               bus.rsp_rdata <= (!bus.req_write && !req_err) ? rdata_ext : 32'd0;
            end else begin
               bus.rsp_err   <= 1'b0;
               bus.rsp_rdata <= rdata_ext;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (store_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[ram_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ==========================================================================
// tb_dmem_responder : directed + random requests against a byte-array model
// Revision : 1.0
// ==========================================================================
module tb_dmem_responder;

   localparam int          DEPTH = 256;
   localparam int          WAITC = 1;
   localparam logic [31:0] MMIO  = 32'h0000_1000;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] target;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .MMIO_ADDR(MMIO)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .target (target)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int rsp_seen = 0;
   int rsp_exp  = 0;

   logic [7:0] mem_m [DEPTH*4];
   logic [3:0] tgt_m;

   always @(negedge clk) if (bus.rsp_valid) rsp_seen++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One request through the bus; the model is updated as of the accept edge.
   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
      int          nb, lat, tmo, exp_lat;
      logic        mmio, e;
      logic [31:0] exp_rd, mword, sh;
      nb     = 1 << sz;
      mmio   = (a[31:2] == MMIO[31:2]);
      e      = (sz == 2'b11) || ((a % nb) != 0) || (!mmio && (a / 4 >= DEPTH));
      exp_rd = 32'd0;
      if (!e) begin
         if (w) begin
            if (mmio) tgt_m = wd[3:0];
            else for (int i = 0; i < nb; i++) begin
               sh = wd >> (8*i);
               mem_m[int'(a) + i] = sh[7:0];
            end
         end else begin
            mword = {28'b0, tgt_m};
            for (int i = 0; i < nb; i++) begin
               if (mmio) begin
                  sh = mword >> (8*((a % 4) + i));
                  exp_rd[8*i +: 8] = sh[7:0];
               end else begin
                  exp_rd[8*i +: 8] = mem_m[int'(a) + i];
               end
            end
            if (!u && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*nb));
         end
      end
      exp_lat = (e || w) ? 1 : 1 + WAITC;

      bus.req_valid    = 1'b1;
      bus.req_write    = w;
      bus.req_size     = sz;
      bus.req_unsigned = u;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      tmo = 0;
      while (!bus.req_ready && tmo < 50) begin
         @(posedge clk); #1; tmo++;
      end
      if (tmo >= 50) check("ready_timeout", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      rsp_exp++;
      if (!hold) bus.req_valid = 1'b0;
      check("target", 32'(target), 32'(tgt_m));
      lat = 1;
      while (!bus.rsp_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("rsp_err", 32'(bus.rsp_err), 32'(e));
      check("rsp_rdata", bus.rsp_rdata, exp_rd);
      check("ready_in_resp", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] a, r;
      logic [1:0]  sz;
      int          pick, t0;
      tgt_m            = 4'd0;
      rst              = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'd0;
      bus.req_wdata    = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rdata", bus.rsp_rdata, 32'd0);
      check("rst_err", 32'(bus.rsp_err), 32'd0);
      check("rst_target", 32'(target), 32'd0);

      // Known contents for the first 32 words so random loads are predictable.
      for (int i = 0; i < 32; i++) issue(1'b1, 2'b10, 1'b0, 32'(i*4), $urandom, 1'b0);

      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
      issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, 1'b0);
      issue(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b0);
      issue(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
      check("sb_merge_model", {mem_m[19], mem_m[18], mem_m[17], mem_m[16]}, 32'h80AD_BEEF);
      issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h8001, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 1'b0);
      issue(1'b1, 2'b01, 1'b0, 32'h21, 32'h5555, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 32'h21, 32'd0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1'b0);
      issue(1'b1, 2'b10, 1'b0, MMIO, 32'h0000_000A, 1'b0);
      issue(1'b0, 2'b10, 1'b0, MMIO, 32'd0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'(DEPTH*4), 32'd0, 1'b0);
      issue(1'b1, 2'b11, 1'b0, 32'h40, 32'h1234, 1'b0);

      // Reset while a load sits in WAIT drops the response and clears target.
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
      bus.req_addr  = 32'h10;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      t0 = rsp_seen;
      rst = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      tgt_m = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wait_no_rsp", 32'(rsp_seen - t0), 32'd0);
      check("rst_wait_ready", 32'(bus.req_ready), 32'd1);
      check("rst_wait_target", 32'(target), 32'd0);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, MMIO, 32'd0, 1'b0);

      // Continuous valid with alternating store/load.
      for (int i = 0; i < 8; i++) begin
         a = 32'(($urandom % 32) * 4);
         issue(1'b1, 2'b10, 1'b0, a, $urandom, 1'b1);
         issue(1'b0, 2'b10, 1'b0, a, 32'd0, (i != 7));
      end

      for (int i = 0; i < 80; i++) begin
         pick = $urandom_range(0, 9);
         sz   = 2'($urandom_range(0, 3));
         r    = $urandom;
         if (pick < 7)       a = 32'($urandom_range(0, 127));
         else if (pick == 7) a = MMIO + 32'($urandom_range(0, 3));
         else if (pick == 8) a = 32'(DEPTH*4) + 32'($urandom_range(0, 15));
         else                a = r;
         issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom));
      end
      bus.req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rsp_count", 32'(rsp_seen), 32'(rsp_exp));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the MEM-stage data-memory interface in the pipelined RISC-V core. Accepts one load/store request at a time from the memory stage over a valid/ready handshake, performs byte/half/word access into an internal word-organised RAM or a 4-bit memory-mapped output register, and returns a single-cycle response with extended load data and an error flag. While busy it deasserts ready, so the pipeline stalls the MEM stage.

## Interface
- DEPTH_WORDS, 256, number of 32-bit RAM words (power of two)
- WAIT_CYCLES, 1, extra read-latency cycles for loads (0..15)
- MMIO_ADDR, 32'h0000_1000, word-aligned address of the `target` output register
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or out-of-range
- target  out  4  memory-mapped output register

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE).
- Accept = req_valid & req_ready at a rising edge; request fields captured then.
- Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]≠0; address neither MMIO_ADDR word nor word index < DEPTH_WORDS (addr[31:2] ≥ DEPTH_WORDS). Errored request: no write, IDLE→RESP, rsp_err=1, rsp_rdata=0.
- Store (no error): commits on the accept edge. Byte: lane addr[1:0] ← wdata[7:0]. Half: lanes {addr[1],0} pair ← wdata[15:0]. Word: all lanes. Other lanes unchanged. IDLE→RESP.
- Store to MMIO_ADDR word (any size, legal alignment): target ← wdata[3:0] on accept edge.
- Load (no error): IDLE→WAIT if WAIT_CYCLES>0 (counter loaded WAIT_CYCLES-1, exits at 0), else IDLE→RESP. Data read at entry to RESP, lane-extracted by captured addr[1:0], sign- or zero-extended per req_unsigned; word ignores req_unsigned. MMIO load returns {28'b0, target}.
- RESP: rsp_valid=1 exactly one cycle, then RESP→IDLE unconditionally (no response back-pressure).
- rsp_rdata/rsp_err hold their values until the next RESP; only meaningful with rsp_valid.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, target=0, wait counter 0. RAM contents not reset.
- Store/error latency: accept edge k → rsp_valid high in cycle k+1 → req_ready high again cycle k+2.
- Load latency: rsp_valid in cycle k+1+WAIT_CYCLES; throughput one request per 2+WAIT_CYCLES cycles.
- rst asserted mid-WAIT/RESP: return to IDLE next edge, pending response dropped, no rsp_valid; a store already committed stays committed; target cleared.
- req_valid while not ready: ignored; initiator holds request until accepted.
- Store and load to same address back-to-back: load returns new data (store committed before load accept).

## Structure
- dmem_pkg: size encodings (SZ_B, SZ_H, SZ_W), FSM state enum, default MMIO_ADDR constant.
- Sub-module dmem_lane_align: combinational store byte-enable/lane-shift and load extract/extend; instantiated once.
- RAM as internal array with byte-enable write; FSM, counter, capture registers in top.

## Test plan
- Reset, then sw 0xDEADBEEF @0x10, lw @0x10 (WAIT_CYCLES=1) → store rsp at k+1 err=0; load rsp_valid at k+2, rdata 0xDEADBEEF.
- sb 0x80 @0x13, then lb @0x13 → 0xFFFFFF80; lbu @0x13 → 0x00000080; lw @0x10 → 0x80ADBEEF.
- sh 0x8001 @0x22 then lh @0x22 → 0xFFFF8001; lh @0x21 → rsp_err=1, rdata 0, memory unchanged.
- sw 0x0000000A @MMIO_ADDR → target=4'hA next edge; lw @MMIO_ADDR → 0x0000000A; lw @DEPTH_WORDS*4 → rsp_err=1.
- Issue lw, assert rst during WAIT → no rsp_valid, req_ready=1 and target=0 after reset; earlier stored words still readable.
- req_valid held high continuously with alternating sw/lw → req_ready pulses correctly, no request lost or duplicated, one rsp_valid per accept.
